// File: rtl/score_char_rom_seq.sv
// Score-to-ASCII character source for the on-screen score field.
// Serial double-dabble BCD conversion, held display, registered char read.
//
// Ports:
//   pclk      : pixel clock, rising edge
//   rst_n     : synchronous reset, active-low
//   score     : binary score, may change at any time
//   char_xy   : character position, 0 = most significant digit
//   char_code : registered 7-bit ASCII code for char_xy (1-cycle latency)
//   busy      : conversion in progress
//   valid     : first conversion after reset has completed
module score_char_rom_seq #(
  parameter int SCORE_W    = 10,
  parameter int DIGITS     = 3,
  parameter int ADDR_W     = 8,
  parameter int LEAD_BLANK = 1
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score,
  input  logic [ADDR_W-1:0]  char_xy,
  output logic [6:0]         char_code,
  output logic               busy,
  output logic               valid
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(SCORE_W + 1);
  localparam logic [63:0] MAXV = 64'(10 ** DIGITS - 1);
  localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};
  localparam logic [CW-1:0] LAST = CW'(SCORE_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_e;

  state_e             st_q;
  logic [SCORE_W-1:0] bin_q;
  logic [SCORE_W-1:0] last_q;
  logic [BW-1:0]      bcd_q;
  logic [BW-1:0]      disp_q;
  logic [CW-1:0]      cnt_q;
  logic               force_q;

  logic [BW-1:0]      bcd_adj;
  logic [BW-1:0]      bcd_d;
  logic               sat;
  logic               start;
  logic [6:0]         code_d;

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Top BCD bit falls off; overflow is caught by sat at LOAD.
  assign bcd_d = {bcd_adj[BW-2:0], bin_q[SCORE_W-1]};

  // last_q holds the score being converted.
  assign sat = 64'(last_q) > MAXV;

  assign start = force_q || (score != last_q);

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
      disp_q  <= '0;
      last_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      force_q <= 1'b1;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (start) begin
            bin_q   <= score;
            last_q  <= score;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            force_q <= 1'b0;
            st_q    <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            st_q <= LOAD;
          end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOAD: begin
          disp_q <= sat ? NINES : bcd_q;
          valid  <= 1'b1;
          // Keep busy high across back-to-back conversions.
          busy   <= (score != last_q);
          st_q   <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // Read path: digit lookup with leading-zero blanking.
  always_comb begin
    logic [3:0]  dig;
    logic        zrun;
    logic [31:0] xy32;
    code_d = 7'h20;
    dig    = 4'd0;
    zrun   = 1'b1;
    xy32   = 32'(char_xy);
    for (int p = 0; p < DIGITS; p++) begin
      dig  = disp_q[(DIGITS-1-p)*4 +: 4];
      zrun = zrun && (dig == 4'd0);
      if (xy32 == 32'(p)) begin
        if (LEAD_BLANK != 0 && zrun && p != DIGITS - 1)
          code_d = 7'h20;
        else
          code_d = {3'b000, dig} + 7'd48;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n)
      char_code <= 7'h20;
    else
      char_code <= code_d;
  end

endmodule
